// File: rtl/riscv_pipeline_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline: ALU_Op classes, default
// widths and the cleared (bubble) control words loaded on flush.
package riscv_pipeline_pkg;

  localparam int DATA_WIDTH_DEFAULT     = 32;
  localparam int REG_ADDR_WIDTH_DEFAULT = 5;

  localparam logic [2:0] R_TYPE = 3'b000;
  localparam logic [2:0] I_TYPE = 3'b001;
  localparam logic [2:0] U_TYPE = 3'b010;
  localparam logic [2:0] B_TYPE = 3'b011;
  localparam logic [2:0] S_TYPE = 3'b100;
  localparam logic [2:0] LOAD   = 3'b101;

  typedef struct packed {
    logic alu_src;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [2:0] funct3;
    logic       funct7;
  } alu_sel_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // R_TYPE with funct3=000, funct7=0 decodes to ADD in the ALU control.
  localparam alu_sel_t ALU_SEL_BUBBLE = '{alu_op: R_TYPE, funct3: 3'b000, funct7: 1'b0};

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: async reset to zero, synchronous clear to
// CLR_VALUE (takes priority over enable), and load enable.
module pipe_reg_en_clr #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= CLR_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures decoded control, ALU selector, operands,
// immediate, register addresses and PC; supports stall (hold) and flush (bubble).
module id_ex_pipeline_register
  import riscv_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [2:0]                alu_op_i,
  input  logic [2:0]                funct3_i,
  input  logic                      funct7_i,
  input  logic                      alu_src_i,
  input  logic                      reg_write_i,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic                      mem_to_reg_i,
  input  logic                      branch_i,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     pc_o,
  output logic [DATA_WIDTH-1:0]     rs1_data_o,
  output logic [DATA_WIDTH-1:0]     rs2_data_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [2:0]                alu_op_o,
  output logic [2:0]                funct3_o,
  output logic                      funct7_o,
  output logic                      alu_src_o,
  output logic                      reg_write_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic                      mem_to_reg_o,
  output logic                      branch_o
);

  // valid_o marks a real instruction in EX. A load with valid_i=0 is handled
  // exactly like a flush, so a bubble never carries a side-effect control.
  logic load_en;
  logic bubble;
  assign load_en = ~stall_i;
  assign bubble  = flush_i | (~stall_i & ~valid_i);

  ctrl_t    ctrl_d, ctrl_q;
  alu_sel_t sel_d, sel_q;

  assign ctrl_d = '{alu_src: alu_src_i, reg_write: reg_write_i, mem_read: mem_read_i,
                    mem_write: mem_write_i, mem_to_reg: mem_to_reg_i, branch: branch_i};
  assign sel_d  = '{alu_op: alu_op_i, funct3: funct3_i, funct7: funct7_i};

  pipe_reg_en_clr #(.WIDTH($bits(ctrl_t)), .CLR_VALUE(CTRL_BUBBLE)) u_ctrl (
    .clk(clk), .reset(reset), .en(load_en), .clr(bubble), .d(ctrl_d), .q(ctrl_q)
  );

  pipe_reg_en_clr #(.WIDTH($bits(alu_sel_t)), .CLR_VALUE(ALU_SEL_BUBBLE)) u_alu_sel (
    .clk(clk), .reset(reset), .en(load_en), .clr(bubble), .d(sel_d), .q(sel_q)
  );

  pipe_reg_en_clr #(.WIDTH(3 * DATA_WIDTH)) u_data (
    .clk(clk), .reset(reset), .en(load_en), .clr(bubble),
    .d({rs1_data_i, rs2_data_i, imm_i}),
    .q({rs1_data_o, rs2_data_o, imm_o})
  );

  pipe_reg_en_clr #(.WIDTH(3 * REG_ADDR_WIDTH)) u_addr (
    .clk(clk), .reset(reset), .en(load_en), .clr(bubble),
    .d({rs1_addr_i, rs2_addr_i, rd_addr_i}),
    .q({rs1_addr_o, rs2_addr_o, rd_addr_o})
  );

  pipe_reg_en_clr #(.WIDTH(DATA_WIDTH)) u_pc (
    .clk(clk), .reset(reset), .en(load_en), .clr(bubble), .d(pc_i), .q(pc_o)
  );

  pipe_reg_en_clr #(.WIDTH(1)) u_valid (
    .clk(clk), .reset(reset), .en(load_en), .clr(bubble), .d(valid_i), .q(valid_o)
  );

  assign alu_src_o    = ctrl_q.alu_src;
  assign reg_write_o  = ctrl_q.reg_write;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign branch_o     = ctrl_q.branch;
  assign alu_op_o     = sel_q.alu_op;
  assign funct3_o     = sel_q.funct3;
  assign funct7_o     = sel_q.funct7;

endmodule
